// File: rtl/hint_pkg.sv
// Shared constants, state encoding and helpers for the hint overlay scheduler.
package hint_pkg;

  // Screen geometry and hint box size.
  localparam int H_RES  = 640;
  localparam int V_RES  = 480;
  localparam int HINT_W = 177;
  localparam int HINT_H = 26;

  // Default hint box placement: centred on screen (231, 227).
  localparam int HINT_X_DEF = (H_RES - HINT_W) / 2;
  localparam int HINT_Y_DEF = (V_RES - HINT_H) / 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_e;

  // Width of a hint ID; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hint_req_fifo.sv
// Pending hint-request queue: synchronous FIFO with flush and a head output.
module hint_req_fifo
  import hint_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         do_push;
  logic         do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  // Next pointer values; flush empties the queue regardless of push/pop.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Pointer registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents only matter between the pointers.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; empty/full come from the pointers alone.
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/hint_scheduler.sv
// Hint overlay sequencer: queues hint requests and shows one hint at a time
// for a fixed number of frames, optionally blinking, followed by a blank gap.
module hint_scheduler
  import hint_pkg::*;
#(
  parameter int NUM_HINTS    = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int SHOW_FRAMES  = 120,
  parameter int GAP_FRAMES   = 15,
  parameter int BLINK_FRAMES = 0,
  parameter int HINT_X       = HINT_X_DEF,
  parameter int HINT_Y       = HINT_Y_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          vsync,
  input  logic                          clear,
  input  logic                          req_valid,
  input  logic [id_width(NUM_HINTS)-1:0] req_id,
  output logic                          req_ready,
  output logic [NUM_HINTS-1:0]          show_en,
  output logic [9:0]                    posx,
  output logic [8:0]                    posy,
  output logic [id_width(NUM_HINTS)-1:0] active_id,
  output logic                          busy
);

  localparam int IW        = id_width(NUM_HINTS);
  localparam int CNT_MAX   = (SHOW_FRAMES > GAP_FRAMES) ?
                             ((SHOW_FRAMES > 2) ? SHOW_FRAMES : 2) :
                             ((GAP_FRAMES > 2) ? GAP_FRAMES : 2);
  localparam int CW        = $clog2(CNT_MAX);
  localparam int BLINK_DIV = (BLINK_FRAMES > 0) ? BLINK_FRAMES : 1;
  localparam logic [CW-1:0] SHOW_LAST = CW'(SHOW_FRAMES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_FRAMES > 0) ? GAP_FRAMES - 1 : 0);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] active_q, active_d;
  logic          vsync_q;
  logic          tick;
  logic          refresh;
  logic          push;
  logic          pop;
  logic [IW-1:0] fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          vis;
  int            blink_phase;

  assign tick    = vsync && !vsync_q;
  // Re-requesting the hint on screen restarts its display time instead of queueing it.
  assign refresh = (state_q == SHOW) && req_valid && (req_id == active_q);
  assign req_ready = !rst && !clear && (!fifo_full || refresh);
  assign push      = req_valid && req_ready && !refresh;
  assign busy      = !rst && ((state_q != IDLE) || !fifo_empty);
  assign active_id = active_q;
  assign posx      = 10'(HINT_X);
  assign posy      = 9'(HINT_Y);

  hint_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (IW)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (clear),
    .push_i      (push),
    .push_data_i (req_id),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Next state, frame counter and active ID; clear overrides the sequencing.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    pop      = 1'b0;
    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            pop      = 1'b1;
            active_d = fifo_head;
            cnt_d    = '0;
            state_d  = SHOW;
          end
        end
        SHOW: begin
          if (refresh) begin
            cnt_d = '0;
          end else if (tick) begin
            if (cnt_q == SHOW_LAST) begin
              cnt_d   = '0;
              state_d = (GAP_FRAMES == 0) ? IDLE : GAP;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        GAP: begin
          if (tick) begin
            if (cnt_q == GAP_LAST) begin
              cnt_d   = '0;
              state_d = IDLE;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counter, active ID and vsync history registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      active_q <= '0;
      vsync_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      vsync_q  <= vsync;
    end
  end

  // Display enable decoded from registered state only.
  always_comb begin
    blink_phase = int'(cnt_q) / BLINK_DIV;
    vis         = (BLINK_FRAMES == 0) || (blink_phase % 2 == 0);
    show_en     = '0;
    if (state_q == SHOW) show_en[active_q] = vis;
  end

endmodule
